// File: rtl/puf_readout_dd_if.sv
// puf_readout_dd_if
// Read-side bundle between the PUF readout buffer and the SPI slave.
//   RD_REQ    SPI -> readout   one-cycle byte-read request
//   CLR       SPI -> readout   synchronous clear of buffer, state and flags
//   RD_DATA   readout -> SPI   returned byte (registered)
//   RD_VALID  readout -> SPI   one-cycle strobe qualifying RD_DATA
//   READY     readout -> SPI   unread response bytes remain
//   BYTE_IDX  readout -> SPI   index of the next byte to be returned
//   OVERRUN   readout -> SPI   sticky: a capture overwrote unread data
//   UNDERRUN  readout -> SPI   sticky: a request arrived with no unread data
// Modports: master = SPI slave side, slave = readout stage.
interface puf_readout_dd_if #(
    parameter int WIDTH = 128
);
    localparam int NUM_BYTES = WIDTH / 8;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    logic             RD_REQ;
    logic             CLR;
    logic [7:0]       RD_DATA;
    logic             RD_VALID;
    logic             READY;
    logic [IDX_W-1:0] BYTE_IDX;
    logic             OVERRUN;
    logic             UNDERRUN;

    modport master (
        output RD_REQ,
        output CLR,
        input  RD_DATA,
        input  RD_VALID,
        input  READY,
        input  BYTE_IDX,
        input  OVERRUN,
        input  UNDERRUN
    );

    modport slave (
        input  RD_REQ,
        input  CLR,
        output RD_DATA,
        output RD_VALID,
        output READY,
        output BYTE_IDX,
        output OVERRUN,
        output UNDERRUN
    );
endinterface

// File: rtl/puf_readout_dd.sv
// puf_readout_dd
// Readout stage behind the delay-difference PUF controller. Every rising
// edge of DONE captures PUF_OUT_REG into a local buffer, which is then
// served one byte per RD_REQ to the SPI slave. Overwrites of unread data
// and reads of an empty buffer are recorded in sticky flags.
// Ports:
//   CLK          system clock, rising edge
//   RESET        asynchronous active-low reset
//   DONE         controller sample-done level
//   PUF_OUT_REG  controller response, valid while DONE is high
//   rd           read-side bundle (slave modport of puf_readout_dd_if)
// Parameters:
//   WIDTH        response width, multiple of 8
//   MSB_FIRST    1: byte 0 is the top byte; 0: byte 0 is bits [7:0]
module puf_readout_dd #(
    parameter int WIDTH     = 128,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             DONE,
    input  logic [WIDTH-1:0] PUF_OUT_REG,
    puf_readout_dd_if.slave  rd
);
    localparam int NUM_BYTES = WIDTH / 8;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FULL = 2'b01,
        ST_BUSY = 2'b10
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] buf_r;
    logic [7:0]       rd_data_r;
    logic             rd_valid_r;
    logic             ready_r;
    logic [IDX_W-1:0] byte_idx_r;
    logic             overrun_r;
    logic             underrun_r;
    logic             done_d_r;
    logic             cap_s;

    // Byte idx of the buffer in serving order; bytes are counted from the
    // top when MSB_FIRST is set.
    function automatic logic [7:0] select_byte(
        input logic [WIDTH-1:0] data,
        input logic [IDX_W-1:0] idx
    );
        logic [IDX_W-1:0] pos;
        logic [WIDTH-1:0] shifted;
        pos     = MSB_FIRST ? (LAST_IDX - idx) : idx;
        shifted = data >> {pos, 3'b000};
        return shifted[7:0];
    endfunction

    // Rising edge of DONE; a DONE already high at reset release counts
    // because done_d_r resets to 0.
    assign cap_s = DONE & ~done_d_r;

    // Buffer FSM with registered outputs: CLR beats capture beats request.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r    <= ST_IDLE;
            buf_r      <= '0;
            rd_data_r  <= 8'h00;
            rd_valid_r <= 1'b0;
            ready_r    <= 1'b0;
            byte_idx_r <= '0;
            overrun_r  <= 1'b0;
            underrun_r <= 1'b0;
            done_d_r   <= 1'b0;
        end else begin
            done_d_r   <= DONE;
            rd_valid_r <= 1'b0;
            if (rd.CLR) begin
                state_r    <= ST_IDLE;
                buf_r      <= '0;
                rd_data_r  <= 8'h00;
                ready_r    <= 1'b0;
                byte_idx_r <= '0;
                overrun_r  <= 1'b0;
                underrun_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE, ST_FULL, ST_BUSY: begin
                        if (cap_s) begin
                            // A same-cycle request is dropped silently.
                            buf_r      <= PUF_OUT_REG;
                            byte_idx_r <= '0;
                            state_r    <= ST_FULL;
                            ready_r    <= 1'b1;
                            if (state_r != ST_IDLE) begin
                                overrun_r <= 1'b1;
                            end
                        end else if (rd.RD_REQ) begin
                            rd_valid_r <= 1'b1;
                            if (state_r == ST_IDLE) begin
                                // Empty read still strobes so SPI framing holds.
                                rd_data_r  <= 8'h00;
                                underrun_r <= 1'b1;
                            end else begin
                                rd_data_r <= select_byte(buf_r, byte_idx_r);
                                if (byte_idx_r == LAST_IDX) begin
                                    byte_idx_r <= '0;
                                    state_r    <= ST_IDLE;
                                    ready_r    <= 1'b0;
                                end else begin
                                    byte_idx_r <= byte_idx_r + IDX_ONE;
                                    state_r    <= ST_BUSY;
                                end
                            end
                        end
                    end
                    default: begin
                        // Corrupted state register: fall back as if cleared.
                        state_r    <= ST_IDLE;
                        buf_r      <= '0;
                        rd_data_r  <= 8'h00;
                        ready_r    <= 1'b0;
                        byte_idx_r <= '0;
                        overrun_r  <= 1'b0;
                        underrun_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rd.RD_DATA  = rd_data_r;
    assign rd.RD_VALID = rd_valid_r;
    assign rd.READY    = ready_r;
    assign rd.BYTE_IDX = byte_idx_r;
    assign rd.OVERRUN  = overrun_r;
    assign rd.UNDERRUN = underrun_r;
endmodule

// File: tb/tb_puf_readout_dd.sv
// Testbench for puf_readout_dd (WIDTH=128, MSB_FIRST=1). Directed scenarios
// compare against constants; a reference model holds the unread bytes as a
// queue and drives the randomized scenario.
module tb_puf_readout_dd;
    localparam int WIDTH = 128;
    localparam int NB    = WIDTH / 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         done  = 1'b0;
    logic [127:0] puf   = '0;

    int checks   = 0;
    int failures = 0;

    puf_readout_dd_if #(.WIDTH(WIDTH)) rd ();

    puf_readout_dd #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
        .CLK         (clk),
        .RESET       (rst_n),
        .DONE        (done),
        .PUF_OUT_REG (puf),
        .rd          (rd)
    );

    always #5 clk = ~clk;

    logic [7:0] exp1 [16] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
                              8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};

    // Reference model: unread bytes in serving order plus flags.
    logic [7:0] q [$];
    logic       m_done_d;
    logic       m_valid;
    logic       m_ovr;
    logic       m_und;
    logic [7:0] m_data;
    logic       exp_ready;
    logic [3:0] exp_idx;

    task automatic model_reset();
        q.delete();
        m_done_d  = 1'b0;
        m_valid   = 1'b0;
        m_ovr     = 1'b0;
        m_und     = 1'b0;
        m_data    = 8'h00;
        exp_ready = 1'b0;
        exp_idx   = 4'd0;
    endtask

    task automatic model_edge();
        logic         cap;
        logic [127:0] t;
        m_valid  = 1'b0;
        cap      = done && !m_done_d;
        m_done_d = done;
        if (rd.CLR) begin
            q.delete();
            m_ovr  = 1'b0;
            m_und  = 1'b0;
            m_data = 8'h00;
        end else if (cap) begin
            if (q.size() != 0) m_ovr = 1'b1;
            q.delete();
            t = puf;
            for (int k = 0; k < NB; k++) begin
                q.push_back(t[127:120]);
                t = t << 8;
            end
        end else if (rd.RD_REQ) begin
            m_valid = 1'b1;
            if (q.size() == 0) begin
                m_data = 8'h00;
                m_und  = 1'b1;
            end else begin
                m_data = q.pop_front();
            end
        end
        exp_ready = (q.size() != 0);
        exp_idx   = (q.size() == 0) ? 4'd0 : 4'(NB - q.size());
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_clr();
        rd.CLR    = 1'b1;
        rd.RD_REQ = 1'b0;
        done      = 1'b0;
        cycle();
        rd.CLR = 1'b0;
    endtask

    task automatic capture(input logic [127:0] v);
        done = 1'b1;
        puf  = v;
        cycle();
        done = 1'b0;
    endtask

    task automatic read_n(input int n);
        rd.RD_REQ = 1'b1;
        repeat (n) cycle();
        rd.RD_REQ = 1'b0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        done      = 1'b0;
        rd.RD_REQ = 1'b0;
        rd.CLR    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rd.RD_DATA !== 8'h00) begin failures++; $display("FAIL rst_data: got %h exp 00", rd.RD_DATA); end
        checks++; if (rd.RD_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b exp 0", rd.RD_VALID); end
        checks++; if (rd.READY !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b exp 0", rd.READY); end
        checks++; if (rd.BYTE_IDX !== 4'd0) begin failures++; $display("FAIL rst_idx: got %0d exp 0", rd.BYTE_IDX); end
        checks++; if (rd.OVERRUN !== 1'b0) begin failures++; $display("FAIL rst_ovr: got %b exp 0", rd.OVERRUN); end
        checks++; if (rd.UNDERRUN !== 1'b0) begin failures++; $display("FAIL rst_und: got %b exp 0", rd.UNDERRUN); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_back_to_back();
        capture(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        checks++; if (rd.READY !== 1'b1) begin failures++; $display("FAIL t1_ready: got %b exp 1", rd.READY); end
        checks++; if (rd.BYTE_IDX !== 4'd0) begin failures++; $display("FAIL t1_idx0: got %0d exp 0", rd.BYTE_IDX); end
        rd.RD_REQ = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cycle();
            checks++; if (rd.RD_VALID !== 1'b1 || rd.RD_DATA !== exp1[i])
                begin failures++; $display("FAIL t1_byte%0d: got v=%b d=%h exp v=1 d=%h", i, rd.RD_VALID, rd.RD_DATA, exp1[i]); end
            checks++; if (rd.READY !== (i < 15))
                begin failures++; $display("FAIL t1_ready%0d: got %b exp %b", i, rd.READY, (i < 15)); end
        end
        rd.RD_REQ = 1'b0;
        cycle();
        checks++; if (rd.RD_VALID !== 1'b0 || rd.RD_DATA !== 8'h10)
            begin failures++; $display("FAIL t1_hold: got v=%b d=%h exp v=0 d=10", rd.RD_VALID, rd.RD_DATA); end
        checks++; if (rd.OVERRUN !== 1'b0 || rd.UNDERRUN !== 1'b0)
            begin failures++; $display("FAIL t1_flags: got o=%b u=%b exp 0 0", rd.OVERRUN, rd.UNDERRUN); end
    endtask

    task automatic test_done_held();
        logic [127:0] p;
        logic [127:0] t;
        do_clr();
        p    = rand128();
        done = 1'b1;
        puf  = p;
        cycle();
        checks++; if (rd.READY !== 1'b1) begin failures++; $display("FAIL t2_ready: got %b exp 1", rd.READY); end
        for (int i = 0; i < 4; i++) begin
            puf = ~p;
            cycle();
        end
        done = 1'b0;
        checks++; if (rd.OVERRUN !== 1'b0 || rd.BYTE_IDX !== 4'd0)
            begin failures++; $display("FAIL t2_single_cap: got o=%b idx=%0d exp o=0 idx=0", rd.OVERRUN, rd.BYTE_IDX); end
        t = p;
        rd.RD_REQ = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cycle();
            checks++; if (rd.RD_DATA !== t[127:120])
                begin failures++; $display("FAIL t2_byte%0d: got %h exp %h", i, rd.RD_DATA, t[127:120]); end
            t = t << 8;
        end
        checks++; if (rd.READY !== 1'b0) begin failures++; $display("FAIL t2_drained: got %b exp 0", rd.READY); end
        cycle();
        rd.RD_REQ = 1'b0;
        checks++; if (rd.RD_DATA !== 8'h00 || rd.RD_VALID !== 1'b1 || rd.UNDERRUN !== 1'b1 || rd.BYTE_IDX !== 4'd0)
            begin failures++; $display("FAIL t2_underrun: got d=%h v=%b u=%b idx=%0d exp 00 1 1 0", rd.RD_DATA, rd.RD_VALID, rd.UNDERRUN, rd.BYTE_IDX); end
    endtask

    task automatic test_overrun();
        do_clr();
        capture(rand128());
        read_n(4);
        checks++; if (rd.BYTE_IDX !== 4'd4 || rd.OVERRUN !== 1'b0)
            begin failures++; $display("FAIL t3_partial: got idx=%0d o=%b exp 4 0", rd.BYTE_IDX, rd.OVERRUN); end
        capture({16{8'hA5}});
        checks++; if (rd.OVERRUN !== 1'b1 || rd.BYTE_IDX !== 4'd0 || rd.READY !== 1'b1)
            begin failures++; $display("FAIL t3_overrun: got o=%b idx=%0d r=%b exp 1 0 1", rd.OVERRUN, rd.BYTE_IDX, rd.READY); end
        read_n(1);
        checks++; if (rd.RD_DATA !== 8'hA5 || rd.BYTE_IDX !== 4'd1)
            begin failures++; $display("FAIL t3_newdata: got d=%h idx=%0d exp A5 1", rd.RD_DATA, rd.BYTE_IDX); end
    endtask

    task automatic test_cap_vs_req();
        logic [127:0] p1;
        logic [127:0] p2;
        p1 = rand128();
        p2 = rand128();
        do_clr();
        done      = 1'b1;
        puf       = p1;
        rd.RD_REQ = 1'b1;
        cycle();
        done = 1'b0;
        checks++; if (rd.RD_VALID !== 1'b0 || rd.UNDERRUN !== 1'b0 || rd.READY !== 1'b1)
            begin failures++; $display("FAIL t4_idle_cap: got v=%b u=%b r=%b exp 0 0 1", rd.RD_VALID, rd.UNDERRUN, rd.READY); end
        cycle();
        checks++; if (rd.RD_DATA !== p1[127:120] || rd.RD_VALID !== 1'b1)
            begin failures++; $display("FAIL t4_first: got d=%h v=%b exp %h 1", rd.RD_DATA, rd.RD_VALID, p1[127:120]); end
        cycle();
        done = 1'b1;
        puf  = p2;
        cycle();
        done = 1'b0;
        checks++; if (rd.RD_VALID !== 1'b0 || rd.OVERRUN !== 1'b1 || rd.BYTE_IDX !== 4'd0 || rd.UNDERRUN !== 1'b0)
            begin failures++; $display("FAIL t4_busy_cap: got v=%b o=%b idx=%0d u=%b exp 0 1 0 0", rd.RD_VALID, rd.OVERRUN, rd.BYTE_IDX, rd.UNDERRUN); end
        cycle();
        rd.RD_REQ = 1'b0;
        checks++; if (rd.RD_DATA !== p2[127:120] || rd.RD_VALID !== 1'b1)
            begin failures++; $display("FAIL t4_newbyte0: got d=%h v=%b exp %h 1", rd.RD_DATA, rd.RD_VALID, p2[127:120]); end
    endtask

    task automatic test_clr();
        do_clr();
        capture(rand128());
        read_n(3);
        capture(rand128());
        read_n(1);
        checks++; if (rd.OVERRUN !== 1'b1) begin failures++; $display("FAIL t5_pre_ovr: got %b exp 1", rd.OVERRUN); end
        rd.CLR = 1'b1;
        done   = 1'b1;
        puf    = rand128();
        cycle();
        rd.CLR = 1'b0;
        checks++; if (rd.READY !== 1'b0 || rd.OVERRUN !== 1'b0 || rd.UNDERRUN !== 1'b0 || rd.BYTE_IDX !== 4'd0)
            begin failures++; $display("FAIL t5_clr: got r=%b o=%b u=%b idx=%0d exp 0 0 0 0", rd.READY, rd.OVERRUN, rd.UNDERRUN, rd.BYTE_IDX); end
        checks++; if (rd.RD_VALID !== 1'b0 || rd.RD_DATA !== 8'h00)
            begin failures++; $display("FAIL t5_clr_data: got v=%b d=%h exp 0 00", rd.RD_VALID, rd.RD_DATA); end
        read_n(1);
        done = 1'b0;
        checks++; if (rd.RD_DATA !== 8'h00 || rd.RD_VALID !== 1'b1 || rd.UNDERRUN !== 1'b1 || rd.READY !== 1'b0)
            begin failures++; $display("FAIL t5_underrun: got d=%h v=%b u=%b r=%b exp 00 1 1 0", rd.RD_DATA, rd.RD_VALID, rd.UNDERRUN, rd.READY); end
    endtask

    task automatic test_async_reset();
        logic [127:0] p;
        p = rand128();
        do_clr();
        capture(rand128());
        rd.RD_REQ = 1'b1;
        cycle();
        cycle();
        checks++; if (rd.RD_VALID !== 1'b1 || rd.BYTE_IDX !== 4'd2)
            begin failures++; $display("FAIL t6_pre: got v=%b idx=%0d exp 1 2", rd.RD_VALID, rd.BYTE_IDX); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rd.RD_VALID !== 1'b0 || rd.READY !== 1'b0 || rd.BYTE_IDX !== 4'd0 || rd.RD_DATA !== 8'h00)
            begin failures++; $display("FAIL t6_async: got v=%b r=%b idx=%0d d=%h exp 0 0 0 00", rd.RD_VALID, rd.READY, rd.BYTE_IDX, rd.RD_DATA); end
        model_reset();
        rd.RD_REQ = 1'b0;
        done      = 1'b1;
        puf       = p;
        @(posedge clk);
        #1;
        checks++; if (rd.READY !== 1'b0) begin failures++; $display("FAIL t6_held: got %b exp 0", rd.READY); end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        checks++; if (rd.READY !== 1'b1 || rd.BYTE_IDX !== 4'd0)
            begin failures++; $display("FAIL t6_cap: got r=%b idx=%0d exp 1 0", rd.READY, rd.BYTE_IDX); end
        cycle();
        done = 1'b0;
        checks++; if (rd.OVERRUN !== 1'b0) begin failures++; $display("FAIL t6_one_cap: got %b exp 0", rd.OVERRUN); end
        read_n(1);
        checks++; if (rd.RD_DATA !== p[127:120] || rd.RD_VALID !== 1'b1)
            begin failures++; $display("FAIL t6_byte0: got d=%h v=%b exp %h 1", rd.RD_DATA, rd.RD_VALID, p[127:120]); end
    endtask

    task automatic test_random();
        do_clr();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) == 0) done = ~done;
            rd.CLR    = ($urandom_range(0, 49) == 0);
            rd.RD_REQ = ($urandom_range(0, 9) < 6);
            puf       = rand128();
            cycle();
            checks++;
            if (rd.RD_VALID !== m_valid || rd.RD_DATA !== m_data || rd.READY !== exp_ready ||
                rd.BYTE_IDX !== exp_idx || rd.OVERRUN !== m_ovr || rd.UNDERRUN !== m_und) begin
                failures++;
                $display("FAIL rand_cyc%0d: got v=%b d=%h r=%b idx=%0d o=%b u=%b exp v=%b d=%h r=%b idx=%0d o=%b u=%b",
                         n, rd.RD_VALID, rd.RD_DATA, rd.READY, rd.BYTE_IDX, rd.OVERRUN, rd.UNDERRUN,
                         m_valid, m_data, exp_ready, exp_idx, m_ovr, m_und);
            end
        end
        rd.CLR    = 1'b0;
        rd.RD_REQ = 1'b0;
        done      = 1'b0;
    endtask

    initial begin
        rd.RD_REQ = 1'b0;
        rd.CLR    = 1'b0;
        model_reset();
        test_reset();
        test_back_to_back();
        test_done_held();
        test_overrun();
        test_cap_vs_req();
        test_clr();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1);
    end
endmodule

// File: doc/puf_readout_dd.md
Name: puf_readout_dd

Overview:
- Downstream readout stage for the delay-difference PUF controller.
- On each rising edge of the controller's DONE, captures the 128-bit PUF_OUT_REG response into a local buffer.
- Serves the buffer byte-by-byte to the SPI slave through a request/valid handshake.
- Tracks buffer occupancy and flags lost (overrun) and empty (underrun) reads so firmware can trust every byte it clocks out.

Parameters:
- WIDTH, 128, response width in bits; must be a multiple of 8. NUM_BYTES = WIDTH/8.
- MSB_FIRST, 1, 1: byte 0 = bits [WIDTH-1:WIDTH-8]; 0: byte 0 = bits [7:0].

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RESET  input  1  asynchronous active-low reset (RESET==0 resets).
- DONE  input  1  controller sample-done level, high for one or more cycles.
- PUF_OUT_REG  input  WIDTH  controller response; valid whenever DONE is high.
- RD_REQ  input  1  one-cycle byte-read request from the SPI slave.
- CLR  input  1  synchronous clear of buffer, state and flags.
- RD_DATA  output  8  returned byte (registered).
- RD_VALID  output  1  one-cycle strobe qualifying RD_DATA.
- READY  output  1  high while unread response bytes remain.
- BYTE_IDX  output  log2(NUM_BYTES)  index of the next byte to be returned.
- OVERRUN  output  1  sticky: a capture overwrote a not-fully-read response.
- UNDERRUN  output  1  sticky: RD_REQ arrived with no unread data.

Behaviour:
- Reset (async, RESET==0): state IDLE; buffer, RD_DATA, BYTE_IDX and DONE_D all 0; RD_VALID, READY, OVERRUN and UNDERRUN all 0.
- Edge detect: DONE_D <= DONE each cycle. cap = DONE & ~DONE_D.
  - DONE already high at reset release gives one capture on the first active edge.
  - DONE held high yields exactly one capture.
- States:
  - IDLE: no data, READY=0.
  - FULL: data loaded, BYTE_IDX=0, READY=1.
  - BUSY: partially read, READY=1.
- Priority per edge: CLR > cap > RD_REQ.
- CLR: next state IDLE; buffer, BYTE_IDX, OVERRUN, UNDERRUN and RD_DATA cleared; RD_VALID=0. A cap or RD_REQ in the same cycle is discarded.
- cap, any state:
  - buffer <= PUF_OUT_REG; BYTE_IDX <= 0; next state FULL.
  - If the state was FULL or BUSY, OVERRUN <= 1.
  - An RD_REQ in the same cycle is ignored: no RD_VALID, no UNDERRUN.
- RD_REQ in FULL or BUSY (no cap, no CLR):
  - Next edge: RD_DATA = byte[BYTE_IDX] per MSB_FIRST, RD_VALID=1 for exactly one cycle, BYTE_IDX++.
  - FULL to BUSY on the first read.
  - On reading byte NUM_BYTES-1: BYTE_IDX wraps to 0, next state IDLE, READY=0 from that edge.
  - Buffer contents are retained but no longer served.
- RD_REQ in IDLE: RD_DATA=8'h00, RD_VALID=1 for one cycle (keeps SPI framing), UNDERRUN <= 1, BYTE_IDX unchanged.
- Latency:
  - cap to READY=1: 1 edge.
  - RD_REQ to RD_VALID: 1 edge.
  - Back-to-back RD_REQ every cycle is supported: one byte per cycle, full drain in NUM_BYTES cycles.
- RD_VALID is 0 in every cycle not produced by a serviced or underrun request. RD_DATA holds its last value between strobes.
- Flags clear only on RESET or CLR.
- Reset mid-read: all outputs return to reset values immediately (async). Any in-flight RD_VALID is suppressed.
- Illegal state encoding: recover to IDLE on the next edge with outputs as after CLR.

Test Plan:
1. Reset release; DONE rises with PUF_OUT_REG=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; 16 consecutive RD_REQ -> READY=1 one edge after capture; RD_VALID bytes 01,23,45,...,32,10 (MSB_FIRST=1); READY=0 after the 16th; OVERRUN=UNDERRUN=0.
2. DONE held high 5 cycles, then 17 RD_REQ -> only one capture; the 17th returns 8'h00 with RD_VALID=1 and UNDERRUN=1, BYTE_IDX=0.
3. Read 4 bytes, then a new DONE edge with PUF_OUT_REG=all 8'hA5 -> OVERRUN=1, BYTE_IDX=0, next read returns A5, state FULL then BUSY.
4. cap and RD_REQ in the same cycle -> no RD_VALID that cycle, UNDERRUN stays 0; the next RD_REQ returns byte 0 of the new data.
5. CLR asserted together with a DONE edge while BUSY with OVERRUN=1 -> IDLE, READY=0, flags 0, capture discarded; a following RD_REQ returns 00 and sets UNDERRUN=1.
6. RESET driven low between two RD_REQ during BUSY -> RD_VALID, READY and BYTE_IDX are 0 asynchronously; after release with DONE high, one capture occurs on the first edge.
